// File: rtl/keystream_xor_serializer.sv
// keystream_xor_serializer
// Holds one keystream block, XORs its words in order (word 0 first) with a
// stream of plaintext words, and presents the ciphertext on a one-deep
// registered valid/ready output. key_done_o tells the keystream generator
// that the buffer is free for the next block.
module keystream_xor_serializer #(
    parameter int WORD_SIZE = 32,
    parameter int KEY_WIDTH = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 key_valid_i,
    output logic                 key_done_o,
    input  logic [WORD_SIZE-1:0] text_i,
    input  logic                 text_valid_i,
    output logic                 text_ready_o,
    output logic [WORD_SIZE-1:0] cipher_o,
    output logic                 cipher_valid_o,
    input  logic                 cipher_ready_i,
    output logic [15:0]          block_count_o
);

    localparam int NUM_WORDS = KEY_WIDTH / WORD_SIZE;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 key_valid_q, key_valid_d;
    logic [KEY_WIDTH-1:0] key_buf_q, key_buf_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] cipher_q, cipher_d;
    logic                 cipher_valid_q, cipher_valid_d;
    logic [15:0]          block_count_q, block_count_d;

    logic [WORD_SIZE-1:0] key_words [NUM_WORDS];
    logic [WORD_SIZE-1:0] word_sel;
    logic                 capture;
    logic                 accept;
    logic                 text_ready;

    // Slice the buffered block into words; word k sits at bit offset WORD_SIZE*k.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
        assign key_words[gi] = key_buf_q[gi*WORD_SIZE +: WORD_SIZE];
    end

    assign word_sel = key_words[idx_q];

    // Handshake qualifiers: capture only on a fresh key_valid edge while empty;
    // accept only when the output register is free or draining this cycle.
    always_comb begin
        capture    = (state_q == EMPTY) && key_valid_i && !key_valid_q;
        text_ready = (state_q == STREAM) && (!cipher_valid_q || cipher_ready_i);
        accept     = text_valid_i && text_ready;
    end

    // Next-state logic for the buffer, word index, output register and counter.
    always_comb begin
        state_d        = state_q;
        key_valid_d    = key_valid_i;
        key_buf_d      = key_buf_q;
        idx_d          = idx_q;
        cipher_d       = cipher_q;
        cipher_valid_d = cipher_valid_q;
        block_count_d  = block_count_q;

        if (capture) begin
            key_buf_d = key_i;
            idx_d     = '0;
            state_d   = STREAM;
        end

        if (accept) begin
            cipher_d       = text_i ^ word_sel;
            cipher_valid_d = 1'b1;
            if (idx_q == LAST_IDX) begin
                // Block exhausted: free the buffer even if the last word is
                // still waiting downstream.
                idx_d         = '0;
                state_d       = EMPTY;
                block_count_d = block_count_q + 16'd1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (cipher_valid_q && cipher_ready_i) begin
            cipher_valid_d = 1'b0;
        end
    end

    // State registers; key_valid_q resets high so a level held through reset
    // does not look like a new block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= EMPTY;
            key_valid_q    <= 1'b1;
            key_buf_q      <= '0;
            idx_q          <= '0;
            cipher_q       <= '0;
            cipher_valid_q <= 1'b0;
            block_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            key_valid_q    <= key_valid_d;
            key_buf_q      <= key_buf_d;
            idx_q          <= idx_d;
            cipher_q       <= cipher_d;
            cipher_valid_q <= cipher_valid_d;
            block_count_q  <= block_count_d;
        end
    end

    assign key_done_o     = (state_q == EMPTY);
    assign text_ready_o   = text_ready;
    assign cipher_o       = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign block_count_o  = block_count_q;

endmodule

// File: tb/tb_keystream_xor_serializer.sv
// Bench for keystream_xor_serializer: a driver issues keystream blocks and
// plaintext words and queues the expected ciphertext; a monitor pops and
// compares every word the DUT hands off downstream.
module tb_keystream_xor_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] key_in;
    logic         key_valid;
    logic         key_done;
    logic [31:0]  text_in;
    logic         text_valid;
    logic         text_ready;
    logic [31:0]  cipher_out;
    logic         cipher_valid;
    logic         cipher_ready;
    logic [15:0]  block_count;

    keystream_xor_serializer #(.WORD_SIZE(32), .KEY_WIDTH(512)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .key_i          (key_in),
        .key_valid_i    (key_valid),
        .key_done_o     (key_done),
        .text_i         (text_in),
        .text_valid_i   (text_valid),
        .text_ready_o   (text_ready),
        .cipher_o       (cipher_out),
        .cipher_valid_o (cipher_valid),
        .cipher_ready_i (cipher_ready),
        .block_count_o  (block_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          blocks_model = 0;
    logic [31:0] ks_q [$];     // keystream words still to be used, in order
    logic [31:0] exp_q [$];    // ciphertext words expected downstream, in order
    logic        held_valid = 1'b0;
    logic [31:0] held_data  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: look at each cycle just after the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    check("hold_valid", {63'd0, cipher_valid}, 64'd1);
                    check("hold_data", {32'd0, cipher_out}, {32'd0, held_data});
                end
                if (cipher_valid && cipher_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h with empty scoreboard", cipher_out);
                    end else begin
                        check("scoreboard", {32'd0, cipher_out}, {32'd0, exp_q.pop_front()});
                        $display("cipher word %h handed off", cipher_out);
                    end
                    held_valid = 1'b0;
                end else if (cipher_valid) begin
                    held_valid = 1'b1;
                    held_data  = cipher_out;
                    check("ready_during_hold", {63'd0, text_ready}, 64'd0);
                end else begin
                    held_valid = 1'b0;
                end
            end
        end
    end

    // One driver cycle; reports whether the word is accepted on the coming edge.
    task automatic step(input logic tv, input logic [31:0] td, input logic cr, output logic acc);
        logic [31:0] e;
        @(negedge clk);
        text_valid   = tv;
        text_in      = td;
        cipher_ready = cr;
        #1;
        acc = tv && text_ready;
        if (acc) begin
            e = ks_q.pop_front() ^ td;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check("latency_valid", {63'd0, cipher_valid}, 64'd1);
            check("latency_data", {32'd0, cipher_out}, {32'd0, e});
        end
    endtask

    // Present a block on a fresh key_valid edge.
    task automatic capture(input logic [511:0] k);
        @(negedge clk);
        key_valid    = 1'b0;
        text_valid   = 1'b0;
        cipher_ready = 1'b1;
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        for (int i = 0; i < 16; i++) ks_q.push_back(k[32*i +: 32]);
        @(negedge clk);
        #1;
        check("key_done_after_capture", {63'd0, key_done}, 64'd0);
    endtask

    // Run one block: nwords accepted words, random valid gaps if rnd, random
    // backpressure if rnd, 5-cycle stall after word index stall_after.
    task automatic run_block(input logic [511:0] k, input int nwords, input logic rnd,
                             input logic ones, input int stall_after);
        int   sent = 0;
        int   cyc = 0;
        int   stall = 0;
        int   waitc = 0;
        logic acc;
        logic tv, cr;
        logic [31:0] td;
        while (waitc < 50) begin
            @(negedge clk);
            #1;
            if (key_done) break;
            waitc++;
        end
        if (waitc >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL key_done_wait: timed out");
        end
        capture(k);
        while (sent < nwords && cyc < 2000) begin
            tv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            td = ones ? 32'hFFFF_FFFF : $urandom;
            if (stall > 0) begin
                cr = 1'b0;
                stall--;
            end else begin
                cr = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            // Occasionally disturb key_valid/key_in mid-block; must be ignored.
            if (rnd && $urandom_range(0, 7) == 0) begin
                key_valid = ~key_valid;
                key_in    = {16{$urandom}};
            end
            step(tv, td, cr, acc);
            if (acc) begin
                sent++;
                if (sent == stall_after + 1) stall = 5;
            end
            cyc++;
        end
        if (sent < nwords) begin
            n_cmp++;
            n_bad++;
            $display("FAIL block_timeout: sent %0d of %0d", sent, nwords);
        end
        if (nwords == 16) begin
            blocks_model++;
            check("key_done_after_last", {63'd0, key_done}, 64'd1);
            check("block_count", {48'd0, block_count}, 64'(blocks_model & 16'hFFFF));
        end
        $display("block done: %0d words, block_count=%0d", sent, block_count);
    endtask

    initial begin
        logic [511:0] k;
        logic         acc;
        #1000000;
        $display("FAIL watchdog: simulation ran too long");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] k;
        rst_n        = 1'b0;
        key_valid    = 1'b1;
        key_in       = {16{32'hDEAD_BEEF}};
        text_valid   = 1'b0;
        text_in      = '0;
        cipher_ready = 1'b1;

        // Reset with key_valid high throughout: no capture on release.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("rst_key_done", {63'd0, key_done}, 64'd1);
            check("rst_cipher_valid", {63'd0, cipher_valid}, 64'd0);
            check("rst_cipher_out", {32'd0, cipher_out}, 64'd0);
            check("rst_block_count", {48'd0, block_count}, 64'd0);
            check("rst_text_ready", {63'd0, text_ready}, 64'd0);
        end

        // Known keystream, all-ones text: ciphertext is the inverted key word.
        for (int i = 0; i < 16; i++) k[32*i +: 32] = 32'h0101_0101 * i;
        run_block(k, 16, 1'b0, 1'b1, -1);
        // Same with a 5-cycle downstream stall after word 3.
        run_block(k, 16, 1'b0, 1'b1, 3);

        // Stale key_valid level after completion must not start a block.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            text_valid = 1'b1;
            #1;
            check("stale_key_done", {63'd0, key_done}, 64'd1);
            check("stale_text_ready", {63'd0, text_ready}, 64'd0);
        end
        text_valid = 1'b0;

        // Random blocks with gaps, backpressure and ignored key edges.
        for (int b = 0; b < 20; b++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_block(k, 16, 1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 14)) : -1);
        end

        // Reset after word 7 of a block: everything returns to reset values at once.
        k = {16{$urandom}};
        run_block(k, 8, 1'b0, 1'b0, -1);
        #2;
        key_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("midrst_key_done", {63'd0, key_done}, 64'd1);
        check("midrst_cipher_valid", {63'd0, cipher_valid}, 64'd0);
        check("midrst_cipher_out", {32'd0, cipher_out}, 64'd0);
        check("midrst_block_count", {48'd0, block_count}, 64'd0);
        check("midrst_text_ready", {63'd0, text_ready}, 64'd0);
        ks_q.delete();
        exp_q.delete();
        blocks_model = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_no_capture", {63'd0, key_done}, 64'd1);

        // Fresh block after reset starts at word 0.
        for (int b = 0; b < 3; b++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_block(k, 16, 1'b1, 1'b0, -1);
        end

        // Drain the last pending word and confirm nothing was lost.
        cipher_ready = 1'b1;
        text_valid   = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
